// File: rtl/sound_frame_controller_pkg.sv
// Shared constants and helpers for the sound frame sequencer: step masks,
// default prescaler period, NR52 address, and the step-to-tick decode.
package sound_frame_controller_pkg;

   localparam int unsigned CLKS_PER_STEP_DEFAULT = 64453;
   localparam logic [15:0] NR52_ADDR_DEFAULT     = 16'hFF26;

   // Bit n set means the tick fires when the sequencer lands on step n.
   localparam logic [7:0] LEN_STEPS   = 8'b01010101;
   localparam logic [7:0] SWEEP_STEPS = 8'b01000100;
   localparam logic [7:0] ENV_STEPS   = 8'b10000000;

   typedef struct packed {
      logic env;
      logic sweep;
      logic len;
   } frame_ticks_t;

   // Which strobes belong to a given (newly entered) sequencer step.
   function automatic frame_ticks_t decode_step(input logic [2:0] step);
      frame_ticks_t t;
      t.len   = LEN_STEPS[step];
      t.sweep = SWEEP_STEPS[step];
      t.env   = ENV_STEPS[step];
      return t;
   endfunction

endpackage

// File: rtl/sound_frame_prescaler.sv
// Frame-sequencer prescaler: divides I_CLK by CLKS_PER_STEP and keeps the
// 3-bit step. O_STEP_ADV is high during the cycle whose edge wraps the count.
module sound_frame_prescaler
   import sound_frame_controller_pkg::*;
#(
   parameter int unsigned CLKS_PER_STEP = CLKS_PER_STEP_DEFAULT
) (
   input  logic       I_CLK,
   input  logic       I_RESET,
   input  logic       I_EN,
   input  logic       I_RESTART,
   output logic [2:0] O_STEP,
   output logic       O_STEP_ADV
);

   localparam logic [23:0] LAST_COUNT = 24'(CLKS_PER_STEP - 1);

   logic [23:0] count_q, count_d;
   logic [2:0]  step_q, step_d;
   logic        wrap;

   // A restart (enable change) always wins over a wrap in the same cycle.
   assign wrap = I_EN && !I_RESTART && (count_q == LAST_COUNT);

   // Next count/step: held at zero while disabled or restarting.
   always_comb begin
      count_d = count_q;
      step_d  = step_q;
      if (!I_EN || I_RESTART) begin
         count_d = '0;
         step_d  = '0;
      end else if (wrap) begin
         count_d = '0;
         step_d  = step_q + 3'd1;
      end else begin
         count_d = count_q + 24'd1;
      end
   end

   // Count and step registers.
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         count_q <= '0;
         step_q  <= '0;
      end else begin
         count_q <= count_d;
         step_q  <= step_d;
      end
   end

   assign O_STEP     = step_q;
   assign O_STEP_ADV = wrap;

endmodule

// File: rtl/sound_frame_controller.sv
// Sound master sequencer: owns NR52 (master enable + channel status read),
// runs the 512 Hz frame sequencer and emits registered length/sweep/envelope
// tick strobes plus a one-cycle clear pulse when sound is powered off.
module sound_frame_controller
   import sound_frame_controller_pkg::*;
#(
   parameter int unsigned CLKS_PER_STEP = CLKS_PER_STEP_DEFAULT,
   parameter logic [15:0] NR52_ADDR     = NR52_ADDR_DEFAULT
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic [15:0] I_IOREG_ADDR,
   inout  wire  [7:0]  IO_IOREG_DATA,
   input  logic        I_IOREG_WE_L,
   input  logic        I_IOREG_RE_L,
   input  logic        I_CH1_ON,
   input  logic        I_CH2_ON,
   input  logic        I_CH3_ON,
   input  logic        I_CH4_ON,
   output logic        O_SOUND_EN,
   output logic        O_LENGTH_TICK,
   output logic        O_SWEEP_TICK,
   output logic        O_ENV_TICK,
   output logic        O_APU_CLEAR,
   output logic [2:0]  O_FRAME_STEP
);

   logic         en_q, en_d;
   logic         clear_q, clear_d;
   frame_ticks_t ticks_q, ticks_d;
   logic         nr52_sel, nr52_wr, wr_en_bit, restart;
   logic [2:0]   step;
   logic         step_adv;
   logic [7:0]   rd_data;
   logic         unused_wr_bits;

   assign nr52_sel  = (I_IOREG_ADDR == NR52_ADDR);
   assign nr52_wr   = !I_IOREG_WE_L && nr52_sel;
   assign wr_en_bit = IO_IOREG_DATA[7];
   // Only bit 7 of NR52 is writable; the rest of the write data is ignored.
   assign unused_wr_bits = ^IO_IOREG_DATA[6:0];

   // Only a real change of the enable bit restarts the sequencer.
   assign restart = nr52_wr && (wr_en_bit != en_q);

   sound_frame_prescaler #(
      .CLKS_PER_STEP (CLKS_PER_STEP)
   ) u_prescaler (
      .I_CLK      (I_CLK),
      .I_RESET    (I_RESET),
      .I_EN       (en_q),
      .I_RESTART  (restart),
      .O_STEP     (step),
      .O_STEP_ADV (step_adv)
   );

   // Next enable, tick strobes (decoded from the step being entered) and clear.
   always_comb begin
      en_d    = en_q;
      ticks_d = '0;
      clear_d = 1'b0;
      if (nr52_wr) begin
         en_d = wr_en_bit;
      end
      if (step_adv) begin
         ticks_d = decode_step(step + 3'd1);
      end
      clear_d = nr52_wr && en_q && !wr_en_bit;
   end

   // NR52 enable, tick and clear registers.
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         en_q    <= 1'b0;
         ticks_q <= '0;
         clear_q <= 1'b0;
      end else begin
         en_q    <= en_d;
         ticks_q <= ticks_d;
         clear_q <= clear_d;
      end
   end

   // Channel status reads back as zero whenever sound is off.
   assign rd_data = {en_q, 3'b111,
                     I_CH4_ON & en_q, I_CH3_ON & en_q,
                     I_CH2_ON & en_q, I_CH1_ON & en_q};

   assign IO_IOREG_DATA = (!I_IOREG_RE_L && nr52_sel) ? rd_data : 8'hzz;

   assign O_SOUND_EN    = en_q;
   assign O_LENGTH_TICK = ticks_q.len;
   assign O_SWEEP_TICK  = ticks_q.sweep;
   assign O_ENV_TICK    = ticks_q.env;
   assign O_APU_CLEAR   = clear_q;
   assign O_FRAME_STEP  = step;

endmodule

// File: tb/tb_sound_frame_controller.sv
// Directed bench for sound_frame_controller with a 4-cycle frame step.
module tb_sound_frame_controller;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        drv;
   logic        we_l, re_l;
   logic        ch1, ch2, ch3, ch4;
   wire  [7:0]  bus;
   logic        sound_en, len_tick, sweep_tick, env_tick, apu_clear;
   logic [2:0]  frame_step;

   int total = 0;
   int bad   = 0;
   logic [6:0] exp_q[$];

   assign bus = drv ? wdata : 8'hzz;

   sound_frame_controller #(
      .CLKS_PER_STEP (4),
      .NR52_ADDR     (16'hFF26)
   ) dut (
      .I_CLK         (clk),
      .I_RESET       (rst),
      .I_IOREG_ADDR  (addr),
      .IO_IOREG_DATA (bus),
      .I_IOREG_WE_L  (we_l),
      .I_IOREG_RE_L  (re_l),
      .I_CH1_ON      (ch1),
      .I_CH2_ON      (ch2),
      .I_CH3_ON      (ch3),
      .I_CH4_ON      (ch4),
      .O_SOUND_EN    (sound_en),
      .O_LENGTH_TICK (len_tick),
      .O_SWEEP_TICK  (sweep_tick),
      .O_ENV_TICK    (env_tick),
      .O_APU_CLEAR   (apu_clear),
      .O_FRAME_STEP  (frame_step)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net in case the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      drv   = 1'b1;
      we_l  = 1'b0;
      @(posedge clk);
      #1;
      we_l  = 1'b1;
      drv   = 1'b0;
      addr  = 16'h0000;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      addr = a;
      re_l = 1'b0;
      #1;
      d    = bus;
      re_l = 1'b1;
      addr = 16'h0000;
   endtask

   function automatic logic [6:0] outs();
      return {apu_clear, env_tick, sweep_tick, len_tick, frame_step};
   endfunction

   initial begin
      logic [7:0] rd;
      logic [6:0] e;
      int ns, n_len, n_sweep, n_env, n_any;

      rst = 1'b1; addr = '0; wdata = '0; drv = 1'b0;
      we_l = 1'b1; re_l = 1'b1;
      ch1 = 1'b0; ch2 = 1'b0; ch3 = 1'b0; ch4 = 1'b0;
      cycles(3);
      rst = 1'b0;
      cycles(1);

      // Reset state after power-up.
      check("rst_en", sound_en, 1'b0);
      check("rst_outs", outs(), 7'h00);
      check("rst_bus_z", bus === 8'hzz, 1'b1);

      // Reset asserted mid-count: async clear, no clear pulse.
      bus_write(16'hFF26, 8'h80);
      cycles(6);
      check("pre_rst_step", frame_step, 3'd1);
      rst = 1'b1;
      #1;
      check("async_rst_en", sound_en, 1'b0);
      check("async_rst_outs", outs(), 7'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycles(5);
      check("post_rst_en", sound_en, 1'b0);
      check("post_rst_outs", outs(), 7'h00);
      bus_read(16'hFF26, rd);
      check("rst_read", rd, 8'h70);

      // Enable and watch 32 cycles of the sequence.
      bus_write(16'hFF26, 8'h80);
      check("en_set", sound_en, 1'b1);
      check("en_step0", outs(), 7'h00);
      n_len = 0; n_sweep = 0; n_env = 0;
      for (int i = 1; i <= 32; i++) begin
         cycles(1);
         ns = (i / 4) % 8;
         e = {4'b0000, 3'(ns)};
         if (i % 4 == 0) begin
            e[3] = (ns % 2 == 0);
            e[4] = (ns == 2) || (ns == 6);
            e[5] = (ns == 7);
         end
         exp_q.push_back(e);
         n_len   += int'(len_tick);
         n_sweep += int'(sweep_tick);
         n_env   += int'(env_tick);
         check("tick_seq", outs(), exp_q.pop_front());
      end
      check("len_count", n_len, 4);
      check("sweep_count", n_sweep, 2);
      check("env_count", n_env, 1);

      // Status read with channels 1 and 3 active.
      ch1 = 1'b1; ch3 = 1'b1;
      bus_read(16'hFF26, rd);
      check("read_en_ch", rd, 8'hF5);

      // Disable at step 5: one clear pulse, sequencer held.
      cycles(20);
      check("at_step5", frame_step, 3'd5);
      bus_write(16'hFF26, 8'h00);
      check("dis_en", sound_en, 1'b0);
      check("dis_outs", outs(), 7'h40);
      n_any = 0;
      for (int i = 0; i < 40; i++) begin
         cycles(1);
         if (outs() != 7'h00) n_any++;
      end
      check("dis_quiet", n_any, 0);
      bus_read(16'hFF26, rd);
      check("read_dis", rd, 8'h70);
      bus_write(16'hFF26, 8'h00);
      check("dis_again_outs", outs(), 7'h00);
      cycles(1);
      check("dis_again_next", outs(), 7'h00);

      // Enable rewrite in a wrap cycle keeps the wrap; disable in a wrap cycle kills it.
      bus_write(16'hFF26, 8'h80);
      cycles(7);
      bus_write(16'hFF26, 8'h80);
      check("reen_en", sound_en, 1'b1);
      check("reen_wrap", outs(), 7'h1A);
      cycles(7);
      check("pre_dis_step", frame_step, 3'd3);
      bus_write(16'hFF26, 8'h00);
      check("wrapdis_en", sound_en, 1'b0);
      check("wrapdis_outs", outs(), 7'h40);
      n_any = 0;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         if (outs() != 7'h00) n_any++;
      end
      check("wrapdis_quiet", n_any, 0);

      // Other addresses do not touch NR52 nor get driven.
      bus_write(16'hFF25, 8'hFF);
      check("other_wr_off", sound_en, 1'b0);
      bus_write(16'hFF26, 8'h80);
      bus_write(16'hFF25, 8'h00);
      check("other_wr_on", sound_en, 1'b1);
      check("other_wr_noclr", apu_clear, 1'b0);
      bus_read(16'hFF25, rd);
      check("other_rd_z", rd === 8'hzz, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
